// File: rtl/lsu_pkg.sv
// Shared load/store-unit types: access widths, DTCM window defaults and alignment helpers.
// Optional DTCM_PARITY_EN build macro is consumed by dtcm_responder, not here.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    SHORT = 2'b01,
    WORD  = 2'b10
  } datawidth_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } dtcm_state_t;

  localparam logic [31:0] DTCM_BASE = 32'h0000_1000;
  localparam int unsigned DTCM_SIZE = 16384;

  // Only the two address LSBs matter; width 2'b11 never aligns.
  function automatic logic is_aligned(input logic [1:0] addr_lsb, input datawidth_t width);
    logic ok;
    case (width)
      BYTE:    ok = 1'b1;
      SHORT:   ok = ~addr_lsb[0];
      WORD:    ok = (addr_lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by an aligned access starting at lane addr_lsb.
  function automatic logic [3:0] lane_mask(input logic [1:0] addr_lsb, input datawidth_t width);
    logic [3:0] m;
    case (width)
      BYTE:    m = 4'b0001 << addr_lsb;
      SHORT:   m = 4'b0011 << addr_lsb;
      WORD:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dtcm_lane_ram.sv
// One byte-lane bank of the DTCM: synchronous write and read ports, read-before-write on collision.
module dtcm_lane_ram #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Nonblocking semantics give the old word to a same-edge read of a written address.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dtcm_responder.sv
// Data TCM target for the LSU: zero-fills after reset, then serves byte/half/word stores and loads.
// Build macro DTCM_PARITY_EN adds a per-lane even-parity bit and the parity_err check.
module dtcm_responder
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DTCM_BASE,
  parameter int unsigned SIZE_BYTES = DTCM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr_write,
  input  logic [1:0]  width_write,
  input  logic [31:0] write_data,
  input  logic        re,
  input  logic [31:0] addr_read,
  input  logic [1:0]  width_read,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        fault_w,
  output logic        fault_r,
  output logic        parity_err
);

  localparam int unsigned DEPTH = SIZE_BYTES / 4;
  localparam int unsigned AW    = $clog2(DEPTH);
`ifdef DTCM_PARITY_EN
  localparam int unsigned LW = 9;
`else
  localparam int unsigned LW = 8;
`endif

  dtcm_state_t   state, state_nx;
  logic [AW-1:0] fill_idx;
  logic          fill_c;
  logic          ready_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (fill_idx == AW'(DEPTH - 1)) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = FILL;
    endcase
  end

  always_comb begin
    fill_c   = 1'b0;
    ready_nx = 1'b0;
    fill_c   = (state == FILL);
    ready_nx = (state_nx == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready    <= 1'b0;
      fill_idx <= '0;
    end else begin
      ready <= ready_nx;
      if (fill_c) fill_idx <= fill_idx + AW'(1);
    end
  end

  // Address decode; offsets wrap so addresses below the base fall out of range.
  logic [31:0] w_off, r_off;
  logic        w_in, r_in, w_al, r_al;
  logic        w_ok, w_mis, r_acc, r_good;
  logic [3:0]  w_mask;

  assign w_off  = addr_write - BASE_ADDR;
  assign r_off  = addr_read - BASE_ADDR;
  assign w_in   = (w_off < 32'(SIZE_BYTES));
  assign r_in   = (r_off < 32'(SIZE_BYTES));
  assign w_al   = is_aligned(w_off[1:0], datawidth_t'(width_write));
  assign r_al   = is_aligned(r_off[1:0], datawidth_t'(width_read));
  assign w_ok   = we & ready & w_in & w_al;
  assign w_mis  = we & ready & w_in & ~w_al;
  assign r_acc  = re & ready;
  assign r_good = r_in & r_al;
  assign w_mask = lane_mask(w_off[1:0], datawidth_t'(width_write));

  logic [LW-1:0] lane_rd [4];

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [1:0]    sh;
    logic [7:0]    lane_byte;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [LW-1:0] ram_wd;

    // Lane l takes source byte (l - start lane) of the LSB-aligned store data.
    assign sh        = 2'(l) - w_off[1:0];
    assign lane_byte = write_data[{sh, 3'b000} +: 8];

    always_comb begin
      ram_we = w_ok & w_mask[l];
      ram_wa = w_off[AW+1:2];
`ifdef DTCM_PARITY_EN
      ram_wd = {^lane_byte, lane_byte};
`else
      ram_wd = lane_byte;
`endif
      if (fill_c) begin
        ram_we = 1'b1;
        ram_wa = fill_idx;
        ram_wd = '0;
      end
    end

    dtcm_lane_ram #(
      .W     (LW),
      .DEPTH (DEPTH)
    ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_wa),
      .wdata (ram_wd),
      .re    (r_acc),
      .raddr (r_off[AW+1:2]),
      .rdata (lane_rd[l])
    );
  end

  // Load-side control captured alongside the RAM read; r_zero_q forces zero data.
  logic [1:0] r_lane_q;
  datawidth_t r_width_q;
  logic       r_zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_q  <= 2'b00;
      r_width_q <= BYTE;
      r_zero_q  <= 1'b1;
      fault_w   <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      fault_w <= w_mis;
      fault_r <= r_acc & r_in & ~r_al;
      if (r_acc) begin
        r_lane_q  <= r_off[1:0];
        r_width_q <= datawidth_t'(width_read);
        r_zero_q  <= ~r_good;
      end
    end
  end

  logic [31:0] rd_word, rd_shift;

  always_comb begin
    rd_word  = {lane_rd[3][7:0], lane_rd[2][7:0], lane_rd[1][7:0], lane_rd[0][7:0]};
    rd_shift = rd_word >> {r_lane_q, 3'b000};
    case (r_width_q)
      BYTE:    read_data = {24'h0, rd_shift[7:0]};
      SHORT:   read_data = {16'h0, rd_shift[15:0]};
      default: read_data = rd_shift;
    endcase
    if (r_zero_q) read_data = '0;
  end

`ifdef DTCM_PARITY_EN
  logic [3:0] r_cov_q;
  logic [3:0] lane_bad;

  // Lanes to check for the load now on read_data; cleared each cycle so the flag pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cov_q <= 4'b0000;
    else     r_cov_q <= (r_acc & r_good) ? lane_mask(r_off[1:0], datawidth_t'(width_read)) : 4'b0000;
  end

  always_comb begin
    for (int l = 0; l < 4; l++) lane_bad[l] = lane_rd[l][8] ^ (^lane_rd[l][7:0]);
  end

  assign parity_err = |(r_cov_q & lane_bad);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dtcm_responder.sv
// Scoreboard bench for dtcm_responder: stimulus queues expectations, a monitor checks every cycle.
module tb_dtcm_responder;
  import lsu_pkg::*;

  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [31:0] addr_write = '0, addr_read = '0, write_data = '0;
  logic [1:0]  width_write = 2'b00, width_read = 2'b00;
  logic [31:0] read_data;
  logic        ready, fault_w, fault_r, parity_err;

  always #5 clk = ~clk;

  dtcm_responder u_dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .addr_write  (addr_write),
    .width_write (width_write),
    .write_data  (write_data),
    .re          (re),
    .addr_read   (addr_read),
    .width_read  (width_read),
    .read_data   (read_data),
    .ready       (ready),
    .fault_w     (fault_w),
    .fault_r     (fault_r),
    .parity_err  (parity_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        fr;
    logic        pe;
  } rexp_t;

  rexp_t rq[$];
  logic  wq[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, issued at a negedge; expectations go to the scoreboard.
  task automatic op(input logic do_w, input logic [31:0] wa, input logic [1:0] ww,
                    input logic [31:0] wd, input logic exp_fw,
                    input logic do_r, input logic [31:0] ra, input logic [1:0] rw,
                    input logic [31:0] exp_d, input logic exp_fr, input logic exp_pe);
    rexp_t e;
    we = do_w; addr_write = wa; width_write = ww; write_data = wd;
    re = do_r; addr_read = ra; width_read = rw;
    if (do_w) wq.push_back(exp_fw);
    if (do_r) begin
      e.data = exp_d; e.fr = exp_fr; e.pe = exp_pe;
      rq.push_back(e);
    end
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d, input logic fw);
    op(1'b1, a, w, d, fw, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d, input logic fr);
    op(1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, a, w, d, fr, 1'b0);
  endtask

  task automatic wait_ready(input string name, input int start);
    int n;
    n = start;
    while (!ready && n < int'(DEPTH) + 16) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  task automatic do_reset(input string name);
    #2 rst = 1'b1;
    #1 chk(name, {31'h0, ready}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares load results one cycle after re, and fault/parity flags every cycle.
  initial begin
    logic  pr, pw, efw;
    rexp_t e;
    forever begin
      @(posedge clk);
      pr = re && !rst;
      pw = we && !rst;
      @(negedge clk);
      if (pr) begin
        if (rq.size() == 0) begin
          chk("sb_read_underflow", 32'h1, 32'h0);
        end else begin
          e = rq.pop_front();
          chk("read_data", read_data, e.data);
          chk("fault_r", {31'h0, fault_r}, {31'h0, e.fr});
          chk("parity_err", {31'h0, parity_err}, {31'h0, e.pe});
        end
      end else begin
        chk("fault_r_idle", {31'h0, fault_r}, 32'h0);
        chk("parity_err_idle", {31'h0, parity_err}, 32'h0);
      end
      efw = 1'b0;
      if (pw) begin
        if (wq.size() == 0) chk("sb_write_underflow", 32'h1, 32'h0);
        else efw = wq.pop_front();
      end
      chk("fault_w", {31'h0, fault_w}, {31'h0, efw});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("ready_in_reset", {31'h0, ready}, 32'h0);
    chk("read_data_in_reset", read_data, 32'h0);
    rst = 1'b0;

    // Accesses during fill are ignored
    st(32'h1000, WORD, 32'hFFFF_FFFF, 1'b0);
    ld(32'h1000, WORD, 32'h0, 1'b0);
    st(32'h1001, SHORT, 32'h1234, 1'b0);
    wait_ready("ready_latency_initial", 3);

    ld(32'h1000, WORD, 32'h0, 1'b0);
    ld(32'h4FFC, WORD, 32'h0, 1'b0);

    st(32'h1000, WORD, 32'hDEAD_BEEF, 1'b0);
    ld(32'h1001, BYTE, 32'h0000_00BE, 1'b0);
    ld(32'h1002, SHORT, 32'h0000_DEAD, 1'b0);
    st(32'h1003, BYTE, 32'h0000_0012, 1'b0);
    ld(32'h1000, WORD, 32'h12AD_BEEF, 1'b0);

    st(32'h1001, SHORT, 32'h0000_AAAA, 1'b1);
    ld(32'h1000, WORD, 32'h12AD_BEEF, 1'b0);
    ld(32'h1002, WORD, 32'h0, 1'b1);
    ld(32'h1003, SHORT, 32'h0, 1'b1);
    ld(32'h1000, 2'b11, 32'h0, 1'b1);
    ld(32'h1000, SHORT, 32'h0000_BEEF, 1'b0);

    // Read-before-write on a same-cycle collision
    op(1'b1, 32'h2000, WORD, 32'h55, 1'b0, 1'b1, 32'h2000, WORD, 32'h0, 1'b0, 1'b0);
    ld(32'h2000, WORD, 32'h55, 1'b0);
    // Both misaligned in one cycle
    op(1'b1, 32'h2001, SHORT, 32'hFFFF, 1'b1, 1'b1, 32'h2002, WORD, 32'h0, 1'b1, 1'b0);
    ld(32'h2000, WORD, 32'h55, 1'b0);

    // Window boundaries
    ld(32'h5000, WORD, 32'h0, 1'b0);
    ld(32'h0FFC, WORD, 32'h0, 1'b0);
    st(32'h5000, WORD, 32'hFFFF_FFFF, 1'b0);
    st(32'h0FFC, WORD, 32'hFFFF_FFFF, 1'b0);
    ld(32'h1000, WORD, 32'h12AD_BEEF, 1'b0);
    st(32'h4FFF, BYTE, 32'hABCD_EF77, 1'b0);
    ld(32'h4FFF, BYTE, 32'h77, 1'b0);
    ld(32'h4FFC, WORD, 32'h7700_0000, 1'b0);
    st(32'h4FFC, SHORT, 32'h0000_C3A5, 1'b0);
    ld(32'h4FFC, WORD, 32'h7700_C3A5, 1'b0);
    ld(32'h4FFE, SHORT, 32'h0000_7700, 1'b0);

    // Reset in RUN: memory cleared again
    do_reset("ready_drop_run");
    wait_ready("ready_latency_after_run_reset", 0);
    ld(32'h1000, WORD, 32'h0, 1'b0);
    ld(32'h2000, WORD, 32'h0, 1'b0);
    ld(32'h4FFC, WORD, 32'h0, 1'b0);

    // Reset mid-fill: fill restarts from index 0
    st(32'h3000, WORD, 32'hCAFE_F00D, 1'b0);
    do_reset("ready_drop_pre");
    repeat (1000) @(negedge clk);
    do_reset("ready_drop_midfill");
    wait_ready("ready_latency_after_midfill_reset", 0);
    ld(32'h3000, WORD, 32'h0, 1'b0);
    ld(32'h4FFC, WORD, 32'h0, 1'b0);

`ifdef DTCM_PARITY_EN
    st(32'h1000, WORD, 32'h0000_00AA, 1'b0);
    ld(32'h1000, BYTE, 32'h0000_00AA, 1'b0);
    u_dut.g_lane[0].u_ram.mem[0][0] = ~u_dut.g_lane[0].u_ram.mem[0][0];
    op(1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h1000, BYTE, 32'h0000_00AB, 1'b0, 1'b1);
    ld(32'h1001, BYTE, 32'h0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(rq.size() + wq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
